// File: rtl/smc_stream.sv
// smc_stream: streaming MOSFET evaluator. It keeps a K-entry sorted list per frame and does a weighted accumulate once the frame ends.
// Optional define SMC_CUTOFF_EN: v_gs = 0 makes the device cut off (vov = 0). Without it, vov wraps.
module smc_stream #(
    parameter int IN_W  = 3,
    parameter int N_TR  = 6,
    parameter int K     = 3,
    parameter int OUT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  w,
    input  logic [IN_W-1:0]  v_gs,
    input  logic [IN_W-1:0]  v_ds,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n
);
    localparam int VAL_W = 3 * IN_W;
    localparam int CNT_W = $clog2(N_TR + 1);
    localparam int IDX_W = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, LOAD, ACC, OUT} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [1:0]         mode_reg;
    logic [VAL_W-1:0]   list_reg  [K];
    logic [VAL_W-1:0]   list_next [K];
    logic [VAL_W-1:0]   base      [K];
    logic [VAL_W-1:0]   ins_large [K];
    logic [VAL_W-1:0]   ins_small [K];
    logic [K-1:0]       ge;
    logic [OUT_W-1:0]   acc_reg, out_n_reg;
    logic               out_valid_reg;

    logic               accept, frame_start, triode;
    logic [1:0]         eff_mode;
    logic [IN_W-1:0]    vov;
    logic [VAL_W-1:0]   w_x, vov_x, vds_x, i_val, g_val, sel, q;
    logic [OUT_W-1:0]   acc_sel, acc_wt;

    assign in_ready    = (state_reg == IDLE) || (state_reg == LOAD);
    assign accept      = in_valid && in_ready;
    assign frame_start = (state_reg == IDLE);
    // The first beat of a frame uses the live mode; later beats use the latched copy.
    assign eff_mode    = frame_start ? mode : mode_reg;
    assign out_valid   = out_valid_reg;
    assign out_n       = out_n_reg;

    always_comb begin
`ifdef SMC_CUTOFF_EN
        vov = (v_gs == '0) ? '0 : v_gs - IN_W'(1);
`else
        vov = v_gs - IN_W'(1);
`endif
        w_x    = VAL_W'(w);
        vov_x  = VAL_W'(vov);
        vds_x  = VAL_W'(v_ds);
        triode = vov > v_ds;
        i_val  = triode ? w_x * (((vov_x * vds_x) << 1) - vds_x * vds_x)
                        : w_x * vov_x * vov_x;
        g_val  = triode ? (w_x * vds_x) << 1 : (w_x * vov_x) << 1;
        sel    = eff_mode[0] ? i_val : g_val;
        q      = sel / VAL_W'(3);
    end

    // Sorted insert, largest-first. A new value goes after the entries equal to it.
    // Largest mode drops the tail. Smallest mode drops the head when q is below it.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_list
            assign base[gi] = frame_start ? {VAL_W{~eff_mode[1]}} : list_reg[gi];
            assign ge[gi]   = base[gi] >= q;
            if (gi == 0) begin : g_head
                assign ins_large[gi] = ge[gi] ? base[gi] : q;
            end else begin : g_body
                assign ins_large[gi] = ge[gi] ? base[gi] : (ge[gi-1] ? q : base[gi-1]);
            end
            if (gi < K - 1) begin : g_shift
                assign ins_small[gi] = ge[gi+1] ? base[gi+1]
                                     : (((gi == 0) || ge[gi]) ? q : base[gi]);
            end else begin : g_tail
                assign ins_small[gi] = ((gi == 0) || ge[gi]) ? q : base[gi];
            end
            assign list_next[gi] = eff_mode[1] ? ins_large[gi]
                                 : ((q < base[0]) ? ins_small[gi] : base[gi]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (N_TR == 1) ? ACC : LOAD;
            LOAD: if (accept && count_reg == CNT_W'(N_TR - 1)) state_next = ACC;
            ACC:  if (idx_reg == IDX_W'(K - 1)) state_next = OUT;
            OUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Rank r of the selected list weighs r+3 in current mode, 1 in gm mode.
    assign acc_sel = OUT_W'(list_reg[idx_reg]);
    assign acc_wt  = mode_reg[0] ? OUT_W'(idx_reg) + OUT_W'(3) : OUT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg     <= '0;
            idx_reg       <= '0;
            mode_reg      <= '0;
            acc_reg       <= '0;
            out_n_reg     <= '0;
            out_valid_reg <= 1'b0;
            for (int i = 0; i < K; i++) list_reg[i] <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            if (accept) begin
                for (int i = 0; i < K; i++) list_reg[i] <= list_next[i];
                count_reg <= frame_start ? CNT_W'(1) : count_reg + CNT_W'(1);
                if (frame_start) begin
                    mode_reg <= mode;
                    acc_reg  <= '0;
                    idx_reg  <= '0;
                end
            end
            if (state_reg == ACC) begin
                acc_reg <= acc_reg + acc_sel * acc_wt;
                idx_reg <= idx_reg + IDX_W'(1);
            end
            if (state_reg == OUT) begin
                out_n_reg     <= acc_reg;
                out_valid_reg <= 1'b1;
                idx_reg       <= '0;
                count_reg     <= '0;
            end
        end
    end
endmodule

// File: doc/smc_stream.md
# smc_stream

Sequential, parametrised successor to the combinational MOSFET evaluator. It accepts one transistor (W, V_GS, V_DS) per valid beat and computes per-device drain current or transconductance. It keeps a running K-entry sorted list of the largest or smallest results and, after N_TR devices, produces a weighted sum in a multi-cycle accumulate phase. It sits between the stimulus interface and the scoring logic of the transistor-analysis datapath.

## Interface
- IN_W, 3: width of W, V_GS, V_DS.
- N_TR, 6: devices per frame; N_TR ≥ K ≥ 1.
- K, 3: number of devices selected.
- OUT_W, 11: out_n width; the result is truncated modulo 2^OUT_W.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat qualifier; a beat is accepted when in_valid && in_ready.
- in_ready  output  1  high in IDLE and LOAD.
- mode  input  2  sampled on the first accepted beat of a frame only. Bit0: 1 = current, 0 = gm. Bit1: 1 = K largest, 0 = K smallest.
- w, v_gs, v_ds  input  IN_W each  device parameters.
- out_valid  output  1  single-cycle result strobe.
- out_n  output  OUT_W  result; holds its value until the next out_valid.

## Operation
- Internal value width VAL_W = 3*IN_W.
- Overdrive: vov = v_gs − 1, computed in IN_W bits. v_gs = 0 is handled per Configuration.
- Triode region, vov > v_ds:
  - I = w*(2*vov*v_ds − v_ds²)
  - g = 2*w*v_ds
- Saturation, otherwise:
  - I = w*vov²
  - g = 2*w*vov
- Scaled value: q = floor(sel/3), where sel = I if mode[0] else g.
- Sorted list: K registers, ordered largest-first.
  - Cleared on frame start to all-zeros (largest mode) or all-ones (smallest mode).
  - Each beat inserts q in one cycle.
  - Ties: the new value goes after existing equal entries.
- Weighting:
  - mode[0] = 0: out_n = Σ q over the selected K.
  - mode[0] = 1: the entry at rank r (r = 0 is the largest of the selected K, in either mode) gets weight r+3.
- FSM states:
  - IDLE: first accepted beat goes to LOAD with beat count = 1.
  - LOAD: accepts beats until count = N_TR, then goes to ACC.
  - ACC: K cycles, one multiply-accumulate of one entry per cycle, then goes to OUT.
  - OUT: one cycle with out_valid = 1, out_n updated, then returns to IDLE.
- Gaps in in_valid during LOAD are allowed; the count and list hold.
- in_valid while in ACC or OUT is ignored (in_ready = 0).

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_n 0, list 0, count 0.
- Latency: last beat accepted at edge t gives out_valid high during the cycle after edge t+K+1. Default latency is 4 cycles after the last beat.
- Throughput: one frame per N_TR + K + 1 cycles minimum.
- The first beat of the next frame is accepted no earlier than the cycle after out_valid.
- rst asserted at any point, mid-LOAD or mid-ACC:
  - the frame is discarded and all registers return to reset values;
  - no out_valid is produced for the aborted frame.
- Arithmetic is unsigned throughout; only out_n truncates.

## Configuration
- SMC_CUTOFF_EN defined: v_gs = 0 forces vov = 0, so the device is cut off and I = g = 0.
- Not defined: vov wraps modulo 2^IN_W. With IN_W = 3, v_gs = 0 gives vov = 7 (legacy behaviour).

## Test plan
- Shared stimulus for the first four tests: six beats w = 1..6, v_gs = 4, v_ds = 7 (saturation, vov = 3).
- mode = 2'b11 on that stimulus → out_n = 18*3 + 15*4 + 12*5 = 174; out_valid 4 cycles after the last beat.
- mode = 2'b01 on that stimulus → 9*3 + 6*4 + 3*5 = 66.
- mode = 2'b10 on that stimulus → 12 + 10 + 8 = 30.
- mode = 2'b00 on that stimulus → 2 + 4 + 6 = 12.
- Same 2'b11 stimulus with in_valid gaps, plus a second frame at mode = 2'b00 → 174 then 12, each with a single out_valid. Driving mode = 2'b00 on beats 2–6 of the first frame does not change the result.
- Six beats w = 7, v_gs = 0, v_ds = 7, mode = 2'b11 → 0 with SMC_CUTOFF_EN, 1368 without.
- rst pulsed after 3 beats, then a clean 2'b11 frame (shared stimulus) → no output for the aborted frame; 174 for the clean frame.
